// File: rtl/multdiv_sched_if.sv
// Handshake bundle between the DX/MW pipeline stages, the multdiv unit and the
// multdiv sequencer. The "slave" view belongs to the sequencer.
interface multdiv_sched_if;
    logic        issue_valid;
    logic        issue_is_div;
    logic [4:0]  issue_rd;
    logic [31:0] op_a;
    logic [31:0] op_b;
    logic        md_ctrl_mult;
    logic        md_ctrl_div;
    logic [31:0] md_op_a;
    logic [31:0] md_op_b;
    logic [31:0] md_result;
    logic        md_exception;
    logic        md_ready;
    logic        wb_busy;
    logic        stall;
    logic        busy;
    logic        commit_valid;
    logic [4:0]  commit_reg;
    logic [31:0] commit_data;
    logic        timeout_err;

    modport slave (
        input  issue_valid, issue_is_div, issue_rd, op_a, op_b,
        input  md_result, md_exception, md_ready, wb_busy,
        output md_ctrl_mult, md_ctrl_div, md_op_a, md_op_b,
        output stall, busy, commit_valid, commit_reg, commit_data, timeout_err
    );

    modport master (
        output issue_valid, issue_is_div, issue_rd, op_a, op_b,
        output md_result, md_exception, md_ready, wb_busy,
        input  md_ctrl_mult, md_ctrl_div, md_op_a, md_op_b,
        input  stall, busy, commit_valid, commit_reg, commit_data, timeout_err
    );
endinterface

// File: rtl/multdiv_sched.sv
// Sequencer for the shared multi-cycle multdiv unit: launches one operation,
// stalls the front end, and retires the result on a free regfile write cycle.
module multdiv_sched #(
    parameter int unsigned TIMEOUT  = 48,
    parameter logic [31:0] MULT_EXC = 32'd4,
    parameter logic [31:0] DIV_EXC  = 32'd5
) (
    input logic            clock,
    input logic            reset,
    multdiv_sched_if.slave bus
);
    localparam int CW = $clog2(TIMEOUT + 1);
    localparam logic [CW-1:0] CNT_LAST = CW'(TIMEOUT - 1);
    localparam logic [CW-1:0] CNT_ONE  = {{(CW-1){1'b0}}, 1'b1};

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        START = 2'd1,
        WAIT  = 2'd2,
        PEND  = 2'd3
    } state_t;

    state_t         state_r;
    state_t         state_s;
    logic [CW-1:0]  cnt_r;
    logic [31:0]    op_a_r;
    logic [31:0]    op_b_r;
    logic [4:0]     rd_r;
    logic           is_div_r;
    logic [31:0]    result_r;
    logic           exc_r;
    logic           ctrl_mult_r;
    logic           ctrl_div_r;
    logic           timeout_r;

    logic           latch_issue_s;
    logic           latch_result_s;
    logic           timeout_s;
    logic           cnt_clr_s;
    logic           cnt_inc_s;
    logic           commit_s;
    logic           stall_s;
    logic [4:0]     commit_reg_s;
    logic [31:0]    commit_data_s;

    // State register
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state_r <= IDLE;
        end else begin
            state_r <= state_s;
        end
    end

    // Next-state decode and per-state control strobes
    always_comb begin
        state_s        = state_r;
        latch_issue_s  = 1'b0;
        latch_result_s = 1'b0;
        timeout_s      = 1'b0;
        cnt_clr_s      = 1'b0;
        cnt_inc_s      = 1'b0;
        commit_s       = 1'b0;
        stall_s        = 1'b1;
        case (state_r)
            IDLE: begin
                stall_s = bus.issue_valid;
                if (bus.issue_valid) begin
                    state_s       = START;
                    latch_issue_s = 1'b1;
                end else begin
                    state_s = IDLE;
                end
            end
            START: begin
                state_s   = WAIT;
                cnt_clr_s = 1'b1;
            end
            WAIT: begin
                // A result arriving on the last allowed cycle still wins over the timeout
                if (bus.md_ready) begin
                    state_s        = PEND;
                    latch_result_s = 1'b1;
                end else if (cnt_r == CNT_LAST) begin
                    state_s   = PEND;
                    timeout_s = 1'b1;
                end else begin
                    cnt_inc_s = 1'b1;
                end
            end
            PEND: begin
                if (!bus.wb_busy) begin
                    state_s  = IDLE;
                    commit_s = exc_r || (rd_r != 5'd0);
                end else begin
                    state_s = PEND;
                end
            end
            default: begin
                state_s = IDLE;
            end
        endcase
    end

    // Operand, result, counter and pulse registers
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            cnt_r       <= {CW{1'b0}};
            op_a_r      <= 32'd0;
            op_b_r      <= 32'd0;
            rd_r        <= 5'd0;
            is_div_r    <= 1'b0;
            result_r    <= 32'd0;
            exc_r       <= 1'b0;
            ctrl_mult_r <= 1'b0;
            ctrl_div_r  <= 1'b0;
            timeout_r   <= 1'b0;
        end else begin
            ctrl_mult_r <= latch_issue_s && !bus.issue_is_div;
            ctrl_div_r  <= latch_issue_s && bus.issue_is_div;
            timeout_r   <= timeout_s;
            if (latch_issue_s) begin
                op_a_r   <= bus.op_a;
                op_b_r   <= bus.op_b;
                rd_r     <= bus.issue_rd;
                is_div_r <= bus.issue_is_div;
                exc_r    <= 1'b0;
            end
            if (cnt_clr_s) begin
                cnt_r <= {CW{1'b0}};
            end else if (cnt_inc_s && (cnt_r != CNT_LAST)) begin
                cnt_r <= cnt_r + CNT_ONE;
            end
            if (latch_result_s) begin
                result_r <= bus.md_result;
                exc_r    <= bus.md_exception;
            end else if (timeout_s) begin
                exc_r <= 1'b1;
            end
        end
    end

    // Exceptions redirect the write to the $r30 status register
    always_comb begin
        commit_reg_s  = rd_r;
        commit_data_s = result_r;
        if (exc_r) begin
            commit_reg_s  = 5'd30;
            commit_data_s = is_div_r ? DIV_EXC : MULT_EXC;
        end else begin
            commit_reg_s  = rd_r;
            commit_data_s = result_r;
        end
    end

    assign bus.md_ctrl_mult = ctrl_mult_r;
    assign bus.md_ctrl_div  = ctrl_div_r;
    assign bus.md_op_a      = op_a_r;
    assign bus.md_op_b      = op_b_r;
    assign bus.stall        = stall_s;
    assign bus.busy         = (state_r != IDLE);
    assign bus.commit_valid = commit_s;
    assign bus.commit_reg   = commit_reg_s;
    assign bus.commit_data  = commit_data_s;
    assign bus.timeout_err  = timeout_r;

endmodule

// File: tb/tb_multdiv_sched.sv
// Scoreboard bench for multdiv_sched: the bench plays DX, MW and the multdiv unit,
// predicts each regfile commit from the operation and a monitor checks them.
module tb_multdiv_sched;
    localparam int TIMEOUT = 48;

    typedef struct {
        logic [4:0]  rd_e;
        logic [31:0] data_e;
    } exp_t;

    logic clock;
    logic reset;
    multdiv_sched_if bus();

    multdiv_sched dut (
        .clock (clock),
        .reset (reset),
        .bus   (bus)
    );

    int   checks      = 0;
    int   failures    = 0;
    int   mult_pulses = 0;
    int   div_pulses  = 0;
    int   to_pulses   = 0;
    exp_t exp_q[$];

    initial clock = 1'b0;
    always #5 clock = ~clock;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%0h expected=%0h at %0t", name, act, exp, $time);
        end
    endtask

    // Monitor: count control pulses and compare each commit with the scoreboard
    always @(negedge clock) begin
        exp_t e;
        if (reset) begin
            if (bus.md_ctrl_mult) mult_pulses++;
            if (bus.md_ctrl_div)  div_pulses++;
            if (bus.timeout_err)  to_pulses++;
            if (bus.commit_valid) begin
                if (exp_q.size() == 0) begin
                    checks++;
                    failures++;
                    $display("FAIL unexpected_commit actual reg=%0d data=%0h expected no commit",
                             bus.commit_reg, bus.commit_data);
                end else begin
                    e = exp_q.pop_front();
                    check("commit_reg", 32'(bus.commit_reg), 32'(e.rd_e));
                    check("commit_data", bus.commit_data, e.data_e);
                    check("commit_wb_free", 32'(bus.wb_busy), 32'd0);
                end
            end
        end
    end

    // mode: 0 = normal result, 1 = multdiv exception, 2 = md_ready never arrives
    task automatic run_op(input logic is_div, input logic [4:0] rd, input logic [31:0] a,
                          input logic [31:0] b, input int mode, input int lat,
                          input int busy_n, input logic junk);
        int          m0 = mult_pulses;
        int          d0 = div_pulses;
        int          t0 = to_pulses;
        logic [31:0] res;
        logic        exc;
        logic        do_commit;
        exp_t        e;
        int          nwait;

        res       = is_div ? (a / b) : (a * b);
        exc       = (mode != 0);
        do_commit = exc || (rd != 5'd0);
        e.rd_e    = exc ? 5'd30 : rd;
        e.data_e  = exc ? (is_div ? 32'd5 : 32'd4) : res;
        if (do_commit) exp_q.push_back(e);

        bus.issue_valid  = 1'b1;
        bus.issue_is_div = is_div;
        bus.issue_rd     = rd;
        bus.op_a         = a;
        bus.op_b         = b;
        bus.wb_busy      = 1'($urandom);
        #1;
        check("stall_on_issue", 32'(bus.stall), 32'd1);
        check("idle_not_busy", 32'(bus.busy), 32'd0);
        @(posedge clock); #1;

        // START: junk on issue and md_ready must be ignored here
        bus.issue_valid  = junk;
        bus.issue_is_div = ~is_div;
        bus.issue_rd     = 5'($urandom);
        bus.op_a         = ~a;
        bus.op_b         = $urandom;
        bus.md_ready     = junk;
        bus.md_result    = $urandom;
        bus.md_exception = junk;
        check("start_mult_pulse", 32'(bus.md_ctrl_mult), 32'(!is_div));
        check("start_div_pulse", 32'(bus.md_ctrl_div), 32'(is_div));
        check("start_op_a", bus.md_op_a, a);
        check("start_op_b", bus.md_op_b, b);
        check("start_stall", 32'(bus.stall), 32'd1);
        @(posedge clock); #1;

        bus.md_ready     = 1'b0;
        bus.md_exception = 1'b0;
        nwait = (mode == 2) ? TIMEOUT : lat;
        for (int i = 0; i < nwait; i++) begin
            bus.wb_busy = 1'($urandom);
            @(posedge clock); #1;
        end
        if (mode != 2) begin
            bus.md_ready     = 1'b1;
            bus.md_result    = res;
            bus.md_exception = (mode == 1);
            @(posedge clock); #1;
            bus.md_ready     = 1'b0;
            bus.md_exception = 1'b0;
            bus.md_result    = $urandom;
        end
        // first PEND cycle
        bus.issue_valid = 1'b0;
        check("timeout_pulse", 32'(bus.timeout_err), 32'(mode == 2));
        for (int i = 0; i < busy_n; i++) begin
            bus.wb_busy = 1'b1;
            #1;
            check("pend_blocked", 32'(bus.commit_valid), 32'd0);
            check("pend_stall", 32'(bus.stall), 32'd1);
            if (do_commit) begin
                check("pend_reg_stable", 32'(bus.commit_reg), 32'(e.rd_e));
                check("pend_data_stable", bus.commit_data, e.data_e);
            end
            @(posedge clock); #1;
        end
        bus.wb_busy = 1'b0;
        #1;
        check("commit_cycle_valid", 32'(bus.commit_valid), 32'(do_commit));
        check("commit_cycle_stall", 32'(bus.stall), 32'd1);
        check("op_a_held", bus.md_op_a, a);
        @(posedge clock); #1;

        check("idle_stall_low", 32'(bus.stall), 32'd0);
        check("idle_busy_low", 32'(bus.busy), 32'd0);
        check("mult_pulse_count", 32'(mult_pulses - m0), 32'(!is_div));
        check("div_pulse_count", 32'(div_pulses - d0), 32'(is_div));
        check("timeout_count", 32'(to_pulses - t0), 32'(mode == 2));
    endtask

    initial begin
        #1000000;
        $display("FAIL watchdog actual=timeout expected=finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        reset            = 1'b0;
        bus.issue_valid  = 1'b0;
        bus.issue_is_div = 1'b0;
        bus.issue_rd     = 5'd0;
        bus.op_a         = 32'd0;
        bus.op_b         = 32'd0;
        bus.md_result    = 32'd0;
        bus.md_exception = 1'b0;
        bus.md_ready     = 1'b0;
        bus.wb_busy      = 1'b0;
        @(posedge clock); @(posedge clock); #1;
        check("reset_stall", 32'(bus.stall), 32'd0);
        check("reset_busy", 32'(bus.busy), 32'd0);
        check("reset_commit", 32'(bus.commit_valid), 32'd0);
        check("reset_op_a", bus.md_op_a, 32'd0);
        reset = 1'b1;
        @(posedge clock); #1;

        run_op(1'b0, 5'd5, 32'd3, 32'd7, 0, 32, 0, 1'b0);
        run_op(1'b1, 5'd9, 32'd100, 32'd7, 1, 10, 0, 1'b0);
        run_op(1'b0, 5'd12, 32'd11, 32'd13, 0, 5, 3, 1'b1);
        run_op(1'b0, 5'd7, 32'd2, 32'd2, 2, 0, 0, 1'b0);
        run_op(1'b0, 5'd0, 32'd4, 32'd4, 0, 4, 0, 1'b0);

        // reset in the middle of WAIT discards the operation
        bus.issue_valid  = 1'b1;
        bus.issue_is_div = 1'b0;
        bus.issue_rd     = 5'd3;
        bus.op_a         = 32'd8;
        bus.op_b         = 32'd9;
        @(posedge clock); #1;
        bus.issue_valid = 1'b0;
        repeat (5) @(posedge clock);
        #1;
        reset = 1'b0;
        #1;
        check("midreset_busy", 32'(bus.busy), 32'd0);
        check("midreset_stall", 32'(bus.stall), 32'd0);
        check("midreset_mult", 32'(bus.md_ctrl_mult), 32'd0);
        check("midreset_op_a", bus.md_op_a, 32'd0);
        check("midreset_op_b", bus.md_op_b, 32'd0);
        check("midreset_commit", 32'(bus.commit_valid), 32'd0);
        check("midreset_data", bus.commit_data, 32'd0);
        @(posedge clock); #1;
        reset         = 1'b1;
        bus.md_ready  = 1'b1;
        bus.md_result = 32'd123;
        @(posedge clock); #1;
        check("stale_ready_busy", 32'(bus.busy), 32'd0);
        bus.md_ready = 1'b0;
        @(posedge clock); #1;
        run_op(1'b1, 5'd11, 32'd6, 32'd2, 0, 3, 0, 1'b0);

        for (int n = 0; n < 40; n++) begin
            logic        rdiv;
            logic [31:0] ra;
            logic [31:0] rb;
            int          r;
            rdiv = 1'($urandom);
            ra   = $urandom;
            rb   = $urandom_range(0, 3) == 0 ? 32'($urandom_range(1, 20)) : $urandom;
            if (rb == 32'd0) rb = 32'd1;
            r = $urandom_range(0, 9);
            run_op(rdiv, 5'($urandom_range(0, 31)), ra, rb,
                   (r == 0) ? 2 : ((r < 3) ? 1 : 0),
                   $urandom_range(0, TIMEOUT - 1), $urandom_range(0, 3), 1'($urandom));
        end

        check("scoreboard_drained", 32'(exp_q.size()), 32'd0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
